// File: rtl/xillybus_mem_bank.sv
// xillybus_mem_bank
//   Dual-port RAM bank. One side is a seekable Xillybus stream: a bus-side
//   pointer walks the RAM on write/read strobes. The other side is a plain
//   fabric port with 1-cycle read-first access.
//
// Ports
//   bus_clk, trn_reset_n        clock, async active-low reset (sync release)
//   quiesce                     core idle: pointer cleared, strobes ignored
//   user_w_mem_*                write stream (wren, data, full, open)
//   user_r_mem_*                read stream (rden, data, empty, eof, open)
//   user_mem_addr[_update]      seek address and one-cycle seek strobe
//   loc_addr/we/wdata/rdata     fabric-side RAM port
//   collision, oor              sticky flags: same-address write clash,
//                               seek beyond the bank
module xillybus_mem_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WRAP   = 1
) (
  input  logic              bus_clk,
  input  logic              trn_reset_n,
  input  logic              quiesce,
  input  logic              user_w_mem_wren,
  input  logic [DATA_W-1:0] user_w_mem_data,
  output logic              user_w_mem_full,
  input  logic              user_w_mem_open,
  input  logic              user_r_mem_rden,
  output logic [DATA_W-1:0] user_r_mem_data,
  output logic              user_r_mem_empty,
  output logic              user_r_mem_eof,
  input  logic              user_r_mem_open,
  input  logic [31:0]       user_mem_addr,
  input  logic              user_mem_addr_update,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic              loc_we,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              collision,
  output logic              oor
);

  localparam int              DEPTH   = 1 << ADDR_W;
  // Pointer value meaning "past the last word" (only reachable with WRAP=0).
  localparam logic [ADDR_W:0] PTR_END = {1'b1, {ADDR_W{1'b0}}};

  // Reset: asserted asynchronously, released through two flops.
  logic [1:0] r_rst_sync;
  logic       r_ram_en;   // parallel copy of r_rst_sync[1], used only as data
  logic       w_rst_n;

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_rst_sync <= '0;
      r_ram_en   <= 1'b0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
      r_ram_en   <= r_rst_sync[0];
    end
  end

  assign w_rst_n = r_rst_sync[1];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_ptr;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_loc_rdata;
  logic              r_collision;
  logic              r_oor;

  logic              w_idle;
  logic              w_end;
  logic              w_bus_we;
  logic              w_bus_re;
  logic              w_same_addr;
  logic              w_loc_we;
  logic              w_seek;
  logic              w_seek_oor;
  logic [ADDR_W-1:0] w_ptr_a;
  logic [ADDR_W:0]   w_ptr_inc;

  assign w_ptr_a     = r_ptr[ADDR_W-1:0];
  assign w_idle      = quiesce || (!user_w_mem_open && !user_r_mem_open);
  assign w_end       = (WRAP == 0) && (r_ptr == PTR_END);
  assign w_seek      = !w_idle && user_mem_addr_update;
  assign w_seek_oor  = |user_mem_addr[31:ADDR_W];
  assign w_bus_we    = !w_idle && !user_mem_addr_update && user_w_mem_wren && !w_end;
  assign w_bus_re    = !w_idle && !user_mem_addr_update && user_r_mem_rden && !w_end;
  assign w_same_addr = (loc_addr == w_ptr_a);
  // Bus write wins a same-address clash; the fabric write is dropped.
  assign w_loc_we    = loc_we && !(w_bus_we && w_same_addr);

  // WRAP=1 keeps the MSB at 0; WRAP=0 lets it reach PTR_END and stop there.
  assign w_ptr_inc = (WRAP != 0) ? {1'b0, w_ptr_a + 1'b1} : r_ptr + 1'b1;

  // RAM array is never reset; writes are blocked while reset is held or
  // still being released so an interrupted burst leaves no partial write.
  always_ff @(posedge bus_clk) begin
    if (r_ram_en) begin
      if (w_bus_we) r_mem[w_ptr_a]  <= user_w_mem_data;
      if (w_loc_we) r_mem[loc_addr] <= loc_wdata;
    end
  end

  always_ff @(posedge bus_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ptr       <= '0;
      r_rdata     <= '0;
      r_loc_rdata <= '0;
      r_collision <= 1'b0;
      r_oor       <= 1'b0;
    end else begin
      r_loc_rdata <= r_mem[loc_addr];
      if (w_bus_re) r_rdata <= r_mem[w_ptr_a];
      if (w_bus_we && loc_we && w_same_addr) r_collision <= 1'b1;
      if (w_seek && w_seek_oor) r_oor <= 1'b1;
      if (w_idle)                  r_ptr <= '0;
      else if (w_seek)             r_ptr <= {1'b0, user_mem_addr[ADDR_W-1:0]};
      else if (w_bus_we || w_bus_re) r_ptr <= w_ptr_inc;
    end
  end

  assign user_w_mem_full  = w_end;
  assign user_r_mem_empty = w_end;
  assign user_r_mem_eof   = w_end;
  assign user_r_mem_data  = r_rdata;
  assign loc_rdata        = r_loc_rdata;
  assign collision        = r_collision;
  assign oor              = r_oor;

endmodule

// File: tb/tb_xillybus_mem_bank.sv
// Bench for xillybus_mem_bank: instance 0 is DATA_W=32/ADDR_W=5/WRAP=1,
// instance 1 is DATA_W=32/ADDR_W=2/WRAP=0. A behavioural model tracks both.
module tb_xillybus_mem_bank;

  logic bus_clk = 1'b0;
  logic trn_reset_n = 1'b1;
  always #5 bus_clk = ~bus_clk;

  logic        q[2], wo[2], ro[2], wren[2], rden[2], upd[2], lwe[2];
  logic [31:0] wd[2], addr[2], lwd[2];
  logic [4:0]  la[2];
  logic        full[2], empty[2], eof[2], coll[2], oor[2];
  logic [31:0] rdata[2], lrdata[2];

  xillybus_mem_bank #(.DATA_W(32), .ADDR_W(5), .WRAP(1)) u_a (
    .bus_clk(bus_clk), .trn_reset_n(trn_reset_n), .quiesce(q[0]),
    .user_w_mem_wren(wren[0]), .user_w_mem_data(wd[0]), .user_w_mem_full(full[0]),
    .user_w_mem_open(wo[0]), .user_r_mem_rden(rden[0]), .user_r_mem_data(rdata[0]),
    .user_r_mem_empty(empty[0]), .user_r_mem_eof(eof[0]), .user_r_mem_open(ro[0]),
    .user_mem_addr(addr[0]), .user_mem_addr_update(upd[0]),
    .loc_addr(la[0]), .loc_we(lwe[0]), .loc_wdata(lwd[0]), .loc_rdata(lrdata[0]),
    .collision(coll[0]), .oor(oor[0]));

  xillybus_mem_bank #(.DATA_W(32), .ADDR_W(2), .WRAP(0)) u_b (
    .bus_clk(bus_clk), .trn_reset_n(trn_reset_n), .quiesce(q[1]),
    .user_w_mem_wren(wren[1]), .user_w_mem_data(wd[1]), .user_w_mem_full(full[1]),
    .user_w_mem_open(wo[1]), .user_r_mem_rden(rden[1]), .user_r_mem_data(rdata[1]),
    .user_r_mem_empty(empty[1]), .user_r_mem_eof(eof[1]), .user_r_mem_open(ro[1]),
    .user_mem_addr(addr[1]), .user_mem_addr_update(upd[1]),
    .loc_addr(la[1][1:0]), .loc_we(lwe[1]), .loc_wdata(lwd[1]), .loc_rdata(lrdata[1]),
    .collision(coll[1]), .oor(oor[1]));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned depth[2] = '{32, 4};
  bit          wrap[2]  = '{1'b1, 1'b0};
  logic [31:0] m_mem[2][32];
  int unsigned m_ptr[2];
  logic [31:0] m_rd[2], m_lrd[2];
  bit          m_coll[2], m_oor[2];
  int          rcnt = 0;
  bit          ldchk = 0;

  task automatic step(input int i);
    bit idle, endb, dw, dr;
    int unsigned a;
    idle = q[i] || (!wo[i] && !ro[i]);
    endb = !wrap[i] && (m_ptr[i] == depth[i]);
    dw   = !idle && !upd[i] && wren[i] && !endb;
    dr   = !idle && !upd[i] && rden[i] && !endb;
    a    = la[i] % depth[i];
    m_lrd[i] = m_mem[i][a];
    if (dr) m_rd[i] = m_mem[i][m_ptr[i]];
    if (lwe[i] && !(dw && a == m_ptr[i])) m_mem[i][a] = lwd[i];
    if (dw) begin
      m_mem[i][m_ptr[i]] = wd[i];
      if (lwe[i] && a == m_ptr[i]) m_coll[i] = 1'b1;
    end
    if (idle) m_ptr[i] = 0;
    else if (upd[i]) begin
      m_ptr[i] = addr[i] % depth[i];
      if (addr[i] >= depth[i]) m_oor[i] = 1'b1;
    end else if (dw || dr)
      m_ptr[i] = wrap[i] ? (m_ptr[i] + 1) % depth[i] : m_ptr[i] + 1;
  endtask

  always @(negedge trn_reset_n) begin
    rcnt = 0;
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_rd[i] = '0; m_lrd[i] = '0; m_coll[i] = 0; m_oor[i] = 0;
    end
  end

  // Two edges after release are still reset inside the block.
  always @(posedge bus_clk) begin
    if (!trn_reset_n || rcnt < 2) begin
      if (trn_reset_n) rcnt++;
      for (int i = 0; i < 2; i++) begin
        m_ptr[i] = 0; m_rd[i] = '0; m_lrd[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) step(i);
    end
  end

  always @(negedge bus_clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("full%0d", i),  full[i],  (!wrap[i] && m_ptr[i] == depth[i]));
      chk($sformatf("empty%0d", i), empty[i], (!wrap[i] && m_ptr[i] == depth[i]));
      chk($sformatf("eof%0d", i),   eof[i],   (!wrap[i] && m_ptr[i] == depth[i]));
      chk($sformatf("rdata%0d", i), rdata[i], m_rd[i]);
      chk($sformatf("coll%0d", i),  coll[i],  m_coll[i]);
      chk($sformatf("oor%0d", i),   oor[i],   m_oor[i]);
      if (ldchk) chk($sformatf("lrdata%0d", i), lrdata[i], m_lrd[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(negedge bus_clk);
  endtask

  task automatic clr(input int i);
    q[i] = 0; wren[i] = 0; rden[i] = 0; upd[i] = 0; lwe[i] = 0;
  endtask

  task automatic seek(input int i, input logic [31:0] a);
    upd[i] = 1; addr[i] = a; tick; upd[i] = 0;
  endtask

  task automatic wr(input int i, input logic [31:0] d);
    wren[i] = 1; wd[i] = d; tick; wren[i] = 0;
  endtask

  task automatic rd(input int i);
    rden[i] = 1; tick; rden[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      clr(i); wo[i] = 0; ro[i] = 0; wd[i] = '0; addr[i] = '0; lwd[i] = '0; la[i] = '0;
      m_ptr[i] = 0; m_rd[i] = '0; m_lrd[i] = '0; m_coll[i] = 0; m_oor[i] = 0;
      for (int k = 0; k < 32; k++) m_mem[i][k] = '0;
    end
    #1 trn_reset_n = 1'b0;
    repeat (3) tick;
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_lrdata", lrdata[0], 32'h0);
    chk("rst_full_b", full[1], 32'h0);
    trn_reset_n = 1'b1;
    repeat (3) tick;

    // Fill both RAMs through the fabric port so every word is known.
    for (int k = 0; k < 32; k++) begin
      lwe[0] = 1; la[0] = 5'(k); lwd[0] = $urandom;
      lwe[1] = (k < 4); la[1] = 5'(k % 4); lwd[1] = $urandom;
      tick;
    end
    lwe[0] = 0; lwe[1] = 0;
    tick;
    ldchk = 1;
    for (int i = 0; i < 2; i++) begin wo[i] = 1; ro[i] = 1; end

    // Sequential write then read of the whole bank.
    seek(0, 0);
    for (int k = 0; k < 32; k++) wr(0, 32'h100 + k);
    seek(0, 0);
    for (int k = 0; k < 32; k++) begin
      rd(0);
      chk("seq_rd", rdata[0], 32'h100 + k);
    end

    // Wrap from the last word to word 0.
    seek(0, 31); wr(0, 32'hA); wr(0, 32'hB);
    seek(0, 31);
    rd(0); chk("wrap_rd31", rdata[0], 32'hA);
    rd(0); chk("wrap_rd0", rdata[0], 32'hB);

    // Same-address clash: bus data wins, fabric read shows the old word.
    seek(0, 4);
    wren[0] = 1; wd[0] = 32'hDEAD; lwe[0] = 1; la[0] = 5'd4; lwd[0] = 32'hBEEF;
    tick;
    wren[0] = 0; lwe[0] = 0;
    chk("clash_lrdata_old", lrdata[0], 32'h104);
    chk("clash_coll", coll[0], 32'h1);
    seek(0, 4); rd(0); chk("clash_rd", rdata[0], 32'hDEAD);

    // Dropping both opens rewinds the pointer; so does quiesce.
    seek(0, 0);
    wr(0, 32'h301); wr(0, 32'h302); wr(0, 32'h303);
    wo[0] = 0; ro[0] = 0; tick; wo[0] = 1; ro[0] = 1;
    rd(0); chk("reopen_rd", rdata[0], 32'h301);
    seek(0, 5); q[0] = 1; tick; q[0] = 0;
    rd(0); chk("quiesce_rd", rdata[0], 32'h301);

    // Saturating bank: end-of-bank flags, dropped write, out-of-range seek.
    seek(1, 3); wr(1, 32'h5); wr(1, 32'h6);
    chk("sat_full", full[1], 32'h1);
    chk("sat_empty", empty[1], 32'h1);
    chk("sat_eof", eof[1], 32'h1);
    seek(1, 0); chk("sat_full_clr", full[1], 32'h0);
    seek(1, 9); chk("sat_oor", oor[1], 32'h1);
    wr(1, 32'h77);
    seek(1, 1); rd(1); chk("sat_ptr1", rdata[1], 32'h77);
    seek(1, 3); rd(1); chk("sat_rd3", rdata[1], 32'h5);
    rd(1); chk("sat_hold", rdata[1], 32'h5);

    // Random traffic on both banks.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        q[i]    = ($urandom_range(0, 49) == 0);
        wo[i]   = ($urandom_range(0, 19) != 0);
        ro[i]   = ($urandom_range(0, 19) != 0);
        upd[i]  = ($urandom_range(0, 9) == 0);
        addr[i] = $urandom_range(0, 2 * depth[i] + 3);
        wren[i] = $urandom_range(0, 1) == 1;
        rden[i] = $urandom_range(0, 1) == 1;
        wd[i]   = $urandom;
        lwe[i]  = ($urandom_range(0, 3) == 0);
        la[i]   = 5'($urandom_range(0, depth[i] - 1));
        lwd[i]  = $urandom;
      end
      tick;
    end
    for (int i = 0; i < 2; i++) begin clr(i); wo[i] = 1; ro[i] = 1; end
    tick;

    // Reset in the middle of a write burst.
    seek(0, 0);
    wren[0] = 1;
    for (int k = 0; k < 3; k++) begin wd[0] = $urandom; tick; end
    @(posedge bus_clk);
    #2 trn_reset_n = 1'b0;
    #1;
    chk("async_rdata", rdata[0], 32'h0);
    chk("async_lrdata", lrdata[0], 32'h0);
    chk("async_coll", coll[0], 32'h0);
    chk("async_oor_b", oor[1], 32'h0);
    tick; wd[0] = $urandom; tick;
    wren[0] = 0;
    trn_reset_n = 1'b1;
    repeat (3) tick;
    seek(0, 0); seek(1, 0);
    for (int k = 0; k < 32; k++) begin
      rden[0] = 1; rden[1] = (k < 4);
      tick;
    end
    clr(0); clr(1);
    repeat (2) tick;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/xillybus_mem_bank.md
XILLYBUS_MEM_BANK -- requirements
Module: xillybus_mem_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width of the seekable stream and RAM; legal values 8, 16, 32.
REQ-002 SHALL have parameter ADDR_W, default 5, RAM address bits; DEPTH = 2^ADDR_W words; legal range 1-16.
REQ-003 SHALL have parameter WRAP, default 1; 1 = pointer wraps DEPTH-1 -> 0, 0 = pointer saturates at DEPTH (end-of-bank).
REQ-004 bus_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 trn_reset_n  in  1  asynchronous active-low reset.
REQ-006 quiesce  in  1  core quiesce; high = bus side idle, pointer cleared.
REQ-007 user_w_mem_wren  in  1  write strobe from core.
REQ-008 user_w_mem_data  in  DATA_W  write word.
REQ-009 user_w_mem_full  out  1  write back-pressure.
REQ-010 user_w_mem_open  in  1  write file open.
REQ-011 user_r_mem_rden  in  1  read strobe from core.
REQ-012 user_r_mem_data  out  DATA_W  read word, valid the cycle after rden.
REQ-013 user_r_mem_empty  out  1  no word available.
REQ-014 user_r_mem_eof  out  1  end-of-file to core.
REQ-015 user_r_mem_open  in  1  read file open.
REQ-016 user_mem_addr  in  32  seek address from core.
REQ-017 user_mem_addr_update  in  1  seek strobe, one cycle.
REQ-018 loc_addr  in  ADDR_W  fabric-side RAM address.
REQ-019 loc_we  in  1  fabric-side write enable.
REQ-020 loc_wdata  in  DATA_W  fabric-side write word.
REQ-021 loc_rdata  out  DATA_W  fabric-side read word, 1-cycle latency.
REQ-022 collision  out  1  sticky: same-address write clash seen.
REQ-023 oor  out  1  sticky: seek address >= DEPTH seen.

Function
REQ-024 SHALL hold DEPTH x DATA_W true dual-port RAM: bus port at pointer ptr (ADDR_W+1 bits), fabric port at loc_addr.
REQ-025 Per-cycle priority on bus side: quiesce > both-opens-low > addr_update > wren/rden.
REQ-026 quiesce high or (user_w_mem_open=0 and user_r_mem_open=0): ptr <= 0; wren/rden/addr_update ignored.
REQ-027 addr_update: ptr <= user_mem_addr[ADDR_W-1:0]; if user_mem_addr >= DEPTH, oor <= 1; wren/rden same cycle ignored.
REQ-028 wren with ptr < DEPTH: RAM[ptr] <= user_w_mem_data; ptr advances.
REQ-029 rden with ptr < DEPTH: user_r_mem_data <= RAM[ptr] next cycle; ptr advances.
REQ-030 wren and rden same cycle: write occurs, read returns pre-write content of RAM[ptr], ptr advances by exactly 1.
REQ-031 Advance: WRAP=1 -> (ptr+1) mod DEPTH; WRAP=0 -> ptr+1, saturating at DEPTH.
REQ-032 WRAP=0, ptr==DEPTH: user_w_mem_full=1, user_r_mem_empty=1, user_r_mem_eof=1; wren/rden dropped, RAM unchanged.
REQ-033 Otherwise full=0, empty=0, eof=0; all three combinational from ptr only.
REQ-034 Fabric port: loc_we writes RAM[loc_addr]; loc_rdata <= RAM[loc_addr] (read-first) every cycle.
REQ-035 Bus write and loc_we same cycle, same address: bus data stored, fabric write discarded, collision <= 1.
REQ-036 user_r_mem_data holds last value when no read occurs.
REQ-037 collision and oor clear only on reset.

Reset
REQ-038 trn_reset_n low: ptr=0, user_r_mem_data=0, loc_rdata=0, collision=0, oor=0, immediately and asynchronously; full=0, empty=0, eof=0 follow.
REQ-039 RAM contents SHALL NOT be reset; reset mid-transfer aborts the access with no partial write.
REQ-040 Deassertion SHALL be taken synchronously inside the block (2-flop synchroniser on release).

Verification
REQ-041 DATA_W=32, ADDR_W=5, WRAP=1: opens=1, seek 0, write 0x100..0x11F (32 words), seek 0, read 32 -> data 0x100..0x11F in order, full/empty/eof never 1.
REQ-042 WRAP=1: seek 31, write 0xA, 0xB -> RAM[31]=0xA, RAM[0]=0xB; ptr=1.
REQ-043 WRAP=0, ADDR_W=2: seek 3, write 0x5, 0x6 -> RAM[3]=0x5, 0x6 dropped, full=empty=eof=1; seek 0 -> all 0; seek 9 -> oor=1, ptr=1.
REQ-044 Same-cycle bus wren (addr 4, 0xDEAD) and loc_we (addr 4, 0xBEEF) -> RAM[4]=0xDEAD, collision=1; loc_rdata next cycle shows old RAM[4].
REQ-045 Write 3 words, drop both opens 1 cycle, reopen, read 1 -> returns RAM[0]; assert trn_reset_n low mid-write burst -> outputs zero at once, RAM unaffected.
